// File: rtl/nexys_starship_spawn_sched.sv
// nexys_starship_spawn_sched
// Central monster-spawn scheduler for the four monster terminals. It issues at most
// one one-hot spawn pulse per timer tick. It enforces a cooldown of gap ticks after
// each spawn and a cap on how many terminals may be Full at once. It folds the
// per-terminal gameover requests into a single gameover_ctrl broadcast.
// Optional feature macro: SPAWN_RAMP_EN. When it is defined, the cooldown loaded at
// each spawn shrinks by one for every 8 spawns so far this game.
module nexys_starship_spawn_sched #(
  parameter int          NUM_TERM   = 4,
  parameter int          MIN_GAP    = 2,
  parameter int          MAX_ACTIVE = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                tick,
  input  logic                play_flag,
  input  logic [NUM_TERM-1:0] term_full,
  input  logic [NUM_TERM-1:0] term_gameover,
  output logic [NUM_TERM-1:0] spawn_req,
  output logic                gameover_ctrl,
  output logic [2:0]          active_cnt,
  output logic [7:0]          spawn_cnt,
  output logic                q_Idle,
  output logic                q_Play,
  output logic                q_Cool,
  output logic                q_Over
);

  localparam logic [3:0]  ST_IDLE      = 4'b0001;
  localparam logic [3:0]  ST_PLAY      = 4'b0010;
  localparam logic [3:0]  ST_COOL      = 4'b0100;
  localparam logic [3:0]  ST_OVER      = 4'b1000;
  localparam int          IDX_W        = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;
  localparam logic [7:0]  MIN_GAP_V    = 8'(MIN_GAP);
  localparam logic [2:0]  MAX_ACTIVE_V = 3'(MAX_ACTIVE);
  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  logic [3:0]          state_r, state_nxt_s;
  logic [15:0]         lfsr_r;
  logic [7:0]          gap_r, gap_load_s;
  logic [NUM_TERM-1:0] spawn_req_r, spawn_nxt_s, win_s;
  logic                gameover_r, gameover_nxt_s;
  logic [2:0]          active_cnt_r;
  logic [7:0]          spawn_cnt_r;
  logic                free_s, abort_s, spawn_go_s;

  function automatic logic [2:0] popcount(input logic [NUM_TERM-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < NUM_TERM; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  assign abort_s = |term_gameover;

  // Rotating-priority search for the first empty terminal, starting at lfsr[1:0]
  always_comb begin
    logic [IDX_W-1:0] idx;
    win_s  = '0;
    free_s = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_TERM; k++) begin
      idx = IDX_W'((int'(lfsr_r[1:0]) + k) % NUM_TERM);
      if (!free_s && !term_full[idx]) begin
        win_s[idx] = 1'b1;
        free_s     = 1'b1;
      end else begin
        free_s = free_s;
      end
    end
  end

  // A spawn fires only on a tick in PLAY when the game is still running, no gameover is requested and the cap allows it
  always_comb begin
    if ((state_r == ST_PLAY) && tick && play_flag && !abort_s &&
        (active_cnt_r < MAX_ACTIVE_V) && free_s) begin
      spawn_go_s = 1'b1;
    end else begin
      spawn_go_s = 1'b0;
    end
  end

`ifdef SPAWN_RAMP_EN
  // Cooldown shrinks by one every 8 spawns, never below zero
  always_comb begin
    if ({3'b000, spawn_cnt_r[7:3]} >= MIN_GAP_V) begin
      gap_load_s = 8'd0;
    end else begin
      gap_load_s = MIN_GAP_V - {3'b000, spawn_cnt_r[7:3]};
    end
  end
`else
  assign gap_load_s = MIN_GAP_V;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a gameover request beats play_flag dropping, which beats normal flow
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (play_flag) state_nxt_s = ST_PLAY;
        else           state_nxt_s = ST_IDLE;
      end
      ST_PLAY: begin
        if (abort_s)         state_nxt_s = ST_OVER;
        else if (!play_flag) state_nxt_s = ST_IDLE;
        else if (spawn_go_s) state_nxt_s = ST_COOL;
        else                 state_nxt_s = ST_PLAY;
      end
      ST_COOL: begin
        if (abort_s)                                        state_nxt_s = ST_OVER;
        else if (!play_flag)                                state_nxt_s = ST_IDLE;
        else if ((gap_r == 8'd0) || (tick && (gap_r == 8'd1))) state_nxt_s = ST_PLAY;
        else                                                state_nxt_s = ST_COOL;
      end
      ST_OVER: begin
        if (!play_flag) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_OVER;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered spawn pulse and gameover broadcast
  always_comb begin
    if (spawn_go_s) spawn_nxt_s = win_s;
    else            spawn_nxt_s = '0;
    if (state_nxt_s == ST_OVER) gameover_nxt_s = 1'b1;
    else                        gameover_nxt_s = 1'b0;
  end

  // Registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spawn_req_r <= '0;
      gameover_r  <= 1'b0;
    end else begin
      spawn_req_r <= spawn_nxt_s;
      gameover_r  <= gameover_nxt_s;
    end
  end

  // LFSR, occupancy count, spawn counter and cooldown counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_r       <= LFSR_SEED;
      active_cnt_r <= 3'd0;
      spawn_cnt_r  <= 8'd0;
      gap_r        <= 8'd0;
    end else begin
      lfsr_r       <= (lfsr_r >> 1) ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
      active_cnt_r <= popcount(term_full);
      if ((state_r == ST_IDLE) && play_flag) begin
        spawn_cnt_r <= 8'd0;
      end else if (spawn_go_s && (spawn_cnt_r != 8'hFF)) begin
        spawn_cnt_r <= spawn_cnt_r + 8'd1;
      end else begin
        spawn_cnt_r <= spawn_cnt_r;
      end
      if (spawn_go_s) begin
        gap_r <= gap_load_s;
      end else if ((state_r == ST_COOL) && tick && (gap_r != 8'd0)) begin
        gap_r <= gap_r - 8'd1;
      end else begin
        gap_r <= gap_r;
      end
    end
  end

  assign spawn_req     = spawn_req_r;
  assign gameover_ctrl = gameover_r;
  assign active_cnt    = active_cnt_r;
  assign spawn_cnt     = spawn_cnt_r;
  assign q_Idle        = state_r[0];
  assign q_Play        = state_r[1];
  assign q_Cool        = state_r[2];
  assign q_Over        = state_r[3];

endmodule
